// File: rtl/stall_ready_fifo.sv
// Show-ahead FIFO that feeds back a registered stall to a stallable upstream pipeline.
// Stall asserts once occupancy reaches DEPTH-SLACK, so the upstream can never overflow it.
module stall_ready_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned SLACK = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       stall,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = $clog2(DEPTH + 1);
    localparam logic [LVL_W-1:0] STALL_LVL = LVL_W'(DEPTH - SLACK);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             stall_q, stall_d;
    logic             wr;
    logic             rd;

    // The upstream holds its output while stalled, so gating on stall_q avoids duplicates.
    assign wr = in_valid & ~stall_q;
    assign rd = out_valid & out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (wr) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({wr, rd})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
        stall_d = (level_d >= STALL_LVL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            stall_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            stall_q  <= stall_d;
        end
    end

    // Storage is deliberately not reset; stale entries are masked by out_valid.
    always_ff @(posedge clk) begin
        if (wr && !rst) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    assign out_valid = (level_q != '0);
    assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
    assign stall     = stall_q;
    assign level     = level_q;

    property p_level_bounded;
        @(posedge clk) disable iff (rst) level_q <= STALL_LVL;
    endproperty
    a_level_bounded: assert property (p_level_bounded);

    property p_stall_tracks_level;
        @(posedge clk) disable iff (rst) stall_q == (level_q >= STALL_LVL);
    endproperty
    a_stall_tracks_level: assert property (p_stall_tracks_level);

endmodule

// File: tb/tb_stall_ready_fifo.sv
// Directed bench for stall_ready_fifo: SLACK=0, SLACK=2 and SLACK=1 instances share one clock.
module tb_stall_ready_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Instance A: SLACK=0
    logic        a_rst, a_in_valid, a_stall, a_out_valid, a_out_ready;
    logic [31:0] a_in_data, a_out_data;
    logic [2:0]  a_level;
    // Instance B: SLACK=2
    logic        b_rst, b_in_valid, b_stall, b_out_valid, b_out_ready;
    logic [31:0] b_in_data, b_out_data;
    logic [2:0]  b_level;
    // Instance C: SLACK=1
    logic        c_rst, c_in_valid, c_stall, c_out_valid, c_out_ready;
    logic [31:0] c_in_data, c_out_data;
    logic [2:0]  c_level;

    stall_ready_fifo #(.WIDTH(32), .DEPTH(4), .SLACK(0)) u_a (
        .clk(clk), .rst(a_rst), .in_valid(a_in_valid), .in_data(a_in_data),
        .stall(a_stall), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_data(a_out_data), .level(a_level)
    );
    stall_ready_fifo #(.WIDTH(32), .DEPTH(4), .SLACK(2)) u_b (
        .clk(clk), .rst(b_rst), .in_valid(b_in_valid), .in_data(b_in_data),
        .stall(b_stall), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data), .level(b_level)
    );
    stall_ready_fifo #(.WIDTH(32), .DEPTH(4), .SLACK(1)) u_c (
        .clk(clk), .rst(c_rst), .in_valid(c_in_valid), .in_data(c_in_data),
        .stall(c_stall), .out_valid(c_out_valid), .out_ready(c_out_ready),
        .out_data(c_out_data), .level(c_level)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
        a_in_valid = 1'b1; b_in_valid = 1'b1; c_in_valid = 1'b1;
        a_in_data = 32'hDEAD; b_in_data = 32'hDEAD; c_in_data = 32'hDEAD;
        a_out_ready = 1'b0; b_out_ready = 1'b0; c_out_ready = 1'b0;
        tick();
        tick();
        checks++;
        if (a_stall !== 1'b0) begin
            failures++; $display("FAIL reset_stall got=%b exp=0", a_stall);
        end
        checks++;
        if (a_out_valid !== 1'b0) begin
            failures++; $display("FAIL reset_out_valid got=%b exp=0", a_out_valid);
        end
        checks++;
        if (a_level !== 3'd0) begin
            failures++; $display("FAIL reset_level got=%0d exp=0", a_level);
        end
        checks++;
        if (a_out_data !== 32'h0) begin
            failures++; $display("FAIL reset_out_data got=%h exp=0", a_out_data);
        end
        checks++;
        if (b_level !== 3'd0 || c_level !== 3'd0 || b_stall !== 1'b0 || c_stall !== 1'b0) begin
            failures++;
            $display("FAIL reset_bc got=%0d/%0d/%b/%b exp=0/0/0/0",
                     b_level, c_level, b_stall, c_stall);
        end
        a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
        a_in_valid = 1'b0; b_in_valid = 1'b0; c_in_valid = 1'b0;
    endtask

    task automatic test_fill;
        logic [2:0] exp_lvl;
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_in_data = 32'hA0 + i;
            tick();
            exp_lvl = 3'(i + 1);
            checks++;
            if (a_level !== exp_lvl) begin
                failures++; $display("FAIL fill_level[%0d] got=%0d exp=%0d", i, a_level, exp_lvl);
            end
            checks++;
            if (a_stall !== (i == 3)) begin
                failures++; $display("FAIL fill_stall[%0d] got=%b exp=%b", i, a_stall, i == 3);
            end
            checks++;
            if (a_out_valid !== 1'b1 || a_out_data !== 32'hA0) begin
                failures++;
                $display("FAIL fill_head[%0d] got=%b/%h exp=1/a0", i, a_out_valid, a_out_data);
            end
        end
        // 0xA4 is presented and held while stalled; it must not be captured.
        a_in_data = 32'hA4;
        tick();
        tick();
        checks++;
        if (a_level !== 3'd4 || a_stall !== 1'b1 || a_out_data !== 32'hA0) begin
            failures++;
            $display("FAIL fill_hold got=%0d/%b/%h exp=4/1/a0", a_level, a_stall, a_out_data);
        end
    endtask

    task automatic test_drain_full;
        a_out_ready = 1'b1;
        tick();
        checks++;
        if (a_level !== 3'd3 || a_stall !== 1'b0 || a_out_data !== 32'hA1) begin
            failures++;
            $display("FAIL drain_pop got=%0d/%b/%h exp=3/0/a1", a_level, a_stall, a_out_data);
        end
        a_out_ready = 1'b0;
        tick();
        checks++;
        if (a_level !== 3'd4 || a_stall !== 1'b1) begin
            failures++; $display("FAIL drain_capture got=%0d/%b exp=4/1", a_level, a_stall);
        end
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if (a_out_valid !== 1'b1 || a_out_data !== 32'hA0 + i) begin
                failures++;
                $display("FAIL drain_order[%0d] got=%b/%h exp=1/%h",
                         i, a_out_valid, a_out_data, 32'hA0 + i);
            end
            tick();
        end
        checks++;
        if (a_level !== 3'd0 || a_out_valid !== 1'b0 || a_out_data !== 32'h0) begin
            failures++;
            $display("FAIL drain_empty got=%0d/%b/%h exp=0/0/0", a_level, a_out_valid, a_out_data);
        end
        a_out_ready = 1'b0;
    endtask

    task automatic test_threshold_wr_rd;
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a_in_data = 32'hB0 + i;
            tick();
        end
        a_in_data   = 32'hB3;
        a_out_ready = 1'b1;
        tick();
        checks++;
        if (a_level !== 3'd3 || a_stall !== 1'b0 || a_out_data !== 32'hB1) begin
            failures++;
            $display("FAIL thresh_wr_rd got=%0d/%b/%h exp=3/0/b1", a_level, a_stall, a_out_data);
        end
        a_in_valid = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            checks++;
            if (a_out_data !== 32'hB0 + i) begin
                failures++;
                $display("FAIL thresh_order[%0d] got=%h exp=%h", i, a_out_data, 32'hB0 + i);
            end
            tick();
        end
        checks++;
        if (a_level !== 3'd0) begin
            failures++; $display("FAIL thresh_empty got=%0d exp=0", a_level);
        end
        a_out_ready = 1'b0;
    endtask

    task automatic test_streaming;
        int bad_lvl = 0;
        int bad_stall = 0;
        int bad_data = 0;
        a_in_valid  = 1'b1;
        a_out_ready = 1'b1;
        a_in_data   = 32'h100;
        tick();
        checks++;
        if (a_out_valid !== 1'b1 || a_out_data !== 32'h100) begin
            failures++;
            $display("FAIL stream_first got=%b/%h exp=1/100", a_out_valid, a_out_data);
        end
        for (int i = 1; i <= 20; i++) begin
            a_in_data = 32'h100 + i;
            tick();
            checks++;
            if (a_level !== 3'd1) begin
                failures++; $display("FAIL stream_level[%0d] got=%0d exp=1", i, a_level);
            end
            checks++;
            if (a_stall !== 1'b0) begin
                failures++; $display("FAIL stream_stall[%0d] got=%b exp=0", i, a_stall);
            end
            checks++;
            if (a_out_data !== 32'h100 + i) begin
                failures++;
                $display("FAIL stream_data[%0d] got=%h exp=%h", i, a_out_data, 32'h100 + i);
            end
        end
        a_in_valid = 1'b0;
        tick();
        checks++;
        if (a_out_valid !== 1'b0 || a_level !== 3'd0) begin
            failures++; $display("FAIL stream_end got=%b/%0d exp=0/0", a_out_valid, a_level);
        end
        a_out_ready = 1'b0;
    endtask

    task automatic test_slack;
        b_out_ready = 1'b0;
        b_in_valid  = 1'b1;
        b_in_data   = 32'hC0;
        tick();
        checks++;
        if (b_level !== 3'd1 || b_stall !== 1'b0) begin
            failures++; $display("FAIL slack_one got=%0d/%b exp=1/0", b_level, b_stall);
        end
        b_in_data = 32'hC1;
        tick();
        checks++;
        if (b_level !== 3'd2 || b_stall !== 1'b1) begin
            failures++; $display("FAIL slack_two got=%0d/%b exp=2/1", b_level, b_stall);
        end
        b_in_data = 32'hC2;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (b_level !== 3'd2 || b_stall !== 1'b1 || b_out_data !== 32'hC0) begin
                failures++;
                $display("FAIL slack_hold[%0d] got=%0d/%b/%h exp=2/1/c0",
                         i, b_level, b_stall, b_out_data);
            end
        end
        b_in_valid = 1'b0;
    endtask

    task automatic test_mid_reset;
        c_out_ready = 1'b0;
        c_in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            c_in_data = 32'hD0 + i;
            tick();
        end
        checks++;
        if (c_level !== 3'd3 || c_stall !== 1'b1) begin
            failures++; $display("FAIL midrst_pre got=%0d/%b exp=3/1", c_level, c_stall);
        end
        c_rst       = 1'b1;
        c_in_data   = 32'h77;
        c_out_ready = 1'b1;
        tick();
        checks++;
        if (c_level !== 3'd0 || c_stall !== 1'b0 || c_out_valid !== 1'b0 || c_out_data !== 32'h0)
        begin
            failures++;
            $display("FAIL midrst_clear got=%0d/%b/%b/%h exp=0/0/0/0",
                     c_level, c_stall, c_out_valid, c_out_data);
        end
        c_rst       = 1'b0;
        c_out_ready = 1'b0;
        c_in_data   = 32'h55;
        tick();
        c_in_valid = 1'b0;
        checks++;
        if (c_out_valid !== 1'b1 || c_out_data !== 32'h55 || c_level !== 3'd1) begin
            failures++;
            $display("FAIL midrst_first got=%b/%h/%0d exp=1/55/1",
                     c_out_valid, c_out_data, c_level);
        end
    endtask

    initial begin
        a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
        a_in_valid = 1'b0; b_in_valid = 1'b0; c_in_valid = 1'b0;
        a_in_data = '0; b_in_data = '0; c_in_data = '0;
        a_out_ready = 1'b0; b_out_ready = 1'b0; c_out_ready = 1'b0;
        #1;
        test_reset();
        test_fill();
        test_drain_full();
        test_threshold_wr_rd();
        test_streaming();
        test_slack();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
